// File: rtl/instr_sequencer_if.sv
// Instruction/register-file/ALU handshake bundle for instr_sequencer.
interface instr_sequencer_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned MODE_W = 3;

    logic              instr_valid;
    logic [DATA_W-1:0] instruction;
    logic              instr_ready;
    logic [DATA_W-1:0] data_bus_out;
    logic [DATA_W-1:0] alu_result;
    logic              zero_flag;
    logic              carry_flag;
    logic              mem_enable;
    logic              read_write;
    logic [SEL_W-1:0]  register_select;
    logic [DATA_W-1:0] data_bus_in;
    logic              alu_enable;
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] immediate_input;
    logic              done;
    logic              illegal;
    logic              zf_q;
    logic              cf_q;

    // Environment side: issues instructions, models register file and ALU
    modport master (
        output instr_valid, instruction, data_bus_out, alu_result, zero_flag, carry_flag,
        input  instr_ready, mem_enable, read_write, register_select, data_bus_in,
               alu_enable, mode, immediate_input, done, illegal, zf_q, cf_q
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instruction, data_bus_out, alu_result, zero_flag, carry_flag,
        output instr_ready, mem_enable, read_write, register_select, data_bus_in,
               alu_enable, mode, immediate_input, done, illegal, zf_q, cf_q
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer driving a 4-entry register file and an ALU.
// All outputs are registered: each transition sets the strobes of the state being entered.
module instr_sequencer (
    input logic               clk,
    input logic               reset,
    instr_sequencer_if.slave  bus
);
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_RS_RD, S_RS_LAT, S_RD_RD, S_ALU, S_CAPT, S_WB, S_DONE
    } state_t;

    typedef enum logic [2:0] {K_IMM, K_RR, K_MI, K_MR, K_ILL} kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] mode;
        logic       cmp;
    } dec_t;

    // Opcode to instruction class, ALU mode and compare (no write-back) flag
    function automatic dec_t f_decode(input logic [3:0] op);
        dec_t d;
        d.kind = K_ILL;
        d.mode = 3'b000;
        d.cmp  = 1'b0;
        case (op)
            4'b1100: begin d.kind = K_IMM; d.mode = 3'b000; end
            4'b1101: begin d.kind = K_IMM; d.mode = 3'b001; end
            4'b1110: begin d.kind = K_IMM; d.mode = 3'b100; end
            4'b1001: begin d.kind = K_IMM; d.mode = 3'b101; end
            4'b1011: begin d.kind = K_IMM; d.mode = 3'b110; end
            4'b1111: begin d.kind = K_IMM; d.mode = 3'b111; d.cmp = 1'b1; end
            4'b0100: begin d.kind = K_RR;  d.mode = 3'b000; end
            4'b0101: begin d.kind = K_RR;  d.mode = 3'b001; end
            4'b0110: begin d.kind = K_RR;  d.mode = 3'b100; end
            4'b1000: begin d.kind = K_RR;  d.mode = 3'b101; end
            4'b1010: begin d.kind = K_RR;  d.mode = 3'b110; end
            4'b0111: begin d.kind = K_RR;  d.mode = 3'b111; d.cmp = 1'b1; end
            4'b0010: d.kind = K_MI;
            4'b0011: d.kind = K_MR;
            default: d.kind = K_ILL;
        endcase
        return d;
    endfunction

    dec_t              w_dec;
    logic [DATA_W-1:0] w_sext;

    state_t            r_state;
    kind_t             r_kind;
    logic              r_cmp;
    logic [1:0]        r_rd;
    logic [1:0]        r_rs;
    logic [2:0]        r_mode;
    logic [DATA_W-1:0] r_operand;
    logic              r_instr_ready;
    logic              r_mem_enable;
    logic              r_read_write;
    logic [1:0]        r_register_select;
    logic [DATA_W-1:0] r_data_bus_in;
    logic              r_alu_enable;
    logic              r_done;
    logic              r_illegal;
    logic              r_zf;
    logic              r_cf;

    assign w_dec  = f_decode(bus.instruction[7:4]);
    assign w_sext = {{6{bus.instruction[1]}}, bus.instruction[1:0]};

    assign bus.instr_ready     = r_instr_ready;
    assign bus.mem_enable      = r_mem_enable;
    assign bus.read_write      = r_read_write;
    assign bus.register_select = r_register_select;
    assign bus.data_bus_in     = r_data_bus_in;
    assign bus.alu_enable      = r_alu_enable;
    assign bus.mode            = r_mode;
    assign bus.immediate_input = r_operand;
    assign bus.done            = r_done;
    assign bus.illegal         = r_illegal;
    assign bus.zf_q            = r_zf;
    assign bus.cf_q            = r_cf;

    // Sequencer FSM with registered strobes; data_bus_in doubles as the result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_kind            <= K_ILL;
            r_cmp             <= 1'b0;
            r_rd              <= 2'b00;
            r_rs              <= 2'b00;
            r_mode            <= 3'b000;
            r_operand         <= '0;
            r_instr_ready     <= 1'b1;
            r_mem_enable      <= 1'b0;
            r_read_write      <= 1'b0;
            r_register_select <= 2'b00;
            r_data_bus_in     <= '0;
            r_alu_enable      <= 1'b0;
            r_done            <= 1'b0;
            r_illegal         <= 1'b0;
            r_zf              <= 1'b0;
            r_cf              <= 1'b0;
        end else begin
            r_instr_ready     <= 1'b0;
            r_mem_enable      <= 1'b0;
            r_read_write      <= 1'b0;
            r_register_select <= 2'b00;
            r_data_bus_in     <= '0;
            r_alu_enable      <= 1'b0;
            r_done            <= 1'b0;
            r_illegal         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_instr_ready <= 1'b1;
                    if (bus.instr_valid) begin
                        r_instr_ready <= 1'b0;
                        r_kind        <= w_dec.kind;
                        r_cmp         <= w_dec.cmp;
                        r_mode        <= w_dec.mode;
                        r_rd          <= bus.instruction[3:2];
                        r_rs          <= bus.instruction[1:0];
                        case (w_dec.kind)
                            K_IMM: begin
                                r_operand         <= w_sext;
                                r_state           <= S_RD_RD;
                                r_mem_enable      <= 1'b1;
                                r_read_write      <= 1'b1;
                                r_register_select <= bus.instruction[3:2];
                            end
                            K_RR, K_MR: begin
                                r_state           <= S_RS_RD;
                                r_mem_enable      <= 1'b1;
                                r_read_write      <= 1'b1;
                                r_register_select <= bus.instruction[1:0];
                            end
                            K_MI: begin
                                r_state           <= S_WB;
                                r_mem_enable      <= 1'b1;
                                r_register_select <= bus.instruction[3:2];
                                r_data_bus_in     <= w_sext;
                            end
                            default: begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RS_RD: begin
                    r_state           <= S_RS_LAT;
                    r_mem_enable      <= 1'b1;
                    r_read_write      <= 1'b1;
                    r_register_select <= r_rs;
                end
                S_RS_LAT: begin
                    r_mem_enable      <= 1'b1;
                    r_register_select <= r_rd;
                    if (r_kind == K_MR) begin
                        r_state       <= S_WB;
                        r_data_bus_in <= bus.data_bus_out;
                    end else begin
                        r_state      <= S_RD_RD;
                        r_read_write <= 1'b1;
                        r_operand    <= bus.data_bus_out;
                    end
                end
                S_RD_RD: begin
                    r_state           <= S_ALU;
                    r_mem_enable      <= 1'b1;
                    r_read_write      <= 1'b1;
                    r_register_select <= r_rd;
                    r_alu_enable      <= 1'b1;
                end
                S_ALU: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_zf <= bus.zero_flag;
                    r_cf <= bus.carry_flag;
                    if (r_cmp) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state           <= S_WB;
                        r_mem_enable      <= 1'b1;
                        r_register_select <= r_rd;
                        r_data_bus_in     <= bus.alu_result;
                    end
                end
                S_WB: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state       <= S_IDLE;
                    r_instr_ready <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: instr_valid  input  1  instruction offered.
REQ-004 SHALL have port: instruction  input  8  [7:4] opcode, [3:2] rd, [1:0] rs or 2-bit immediate.
REQ-005 SHALL have port: instr_ready  output  1  sequencer idle, can accept.
REQ-006 SHALL have port: data_bus_out  input  8  register-file read data, valid the cycle after a read is issued.
REQ-007 SHALL have port: alu_result  input  8  ALU result, valid the cycle after alu_enable.
REQ-008 SHALL have ports: zero_flag, carry_flag  input  1 each  ALU flags, same timing as alu_result.
REQ-009 SHALL have ports: mem_enable, read_write (1=read, 0=write)  output  1 each  register-file strobes.
REQ-010 SHALL have port: register_select  output  2  register-file address.
REQ-011 SHALL have port: data_bus_in  output  8  register-file write data.
REQ-012 SHALL have ports: alu_enable  output  1; mode  output  3; immediate_input  output  8  ALU controls and second operand.
REQ-013 SHALL have ports: done, illegal, zf_q, cf_q  output  1 each  completion pulse, bad opcode, latched flags.

Function
REQ-014 Opcode map SHALL be: SMI 1100/mode 000, SBI 1101/001, ANI 1110/100, ORI 1001/101, XRI 1011/110, CMI 1111/111; SUM 0100/000, SB 0101/001, ANR 0110/100, ORR 1000/101, XRR 1010/110, CM 0111/111; MI 0010; MR 0011; LD 0000 and ST 0001 illegal.
REQ-015 Accept SHALL occur on an edge with instr_valid=1 and instr_ready=1; instruction latched; instr_valid ignored otherwise.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 States: IDLE, RS_RD, RS_LAT, RD_RD, ALU, CAPT, WB, DONE.
REQ-018 RS_RD/RS_LAT: mem_enable=1, read_write=1, register_select=rs; operand register loads data_bus_out at end of RS_LAT.
REQ-019 RD_RD: mem_enable=1, read_write=1, register_select=rd.
REQ-020 ALU: as RD_RD plus alu_enable=1, mode per REQ-014.
REQ-021 CAPT: all strobes 0; result register loads alu_result; zf_q/cf_q load zero_flag/carry_flag.
REQ-022 WB: mem_enable=1, read_write=0, register_select=rd, data_bus_in = result (ALU ops), sign-extended immediate (MI), operand register (MR); held exactly one cycle.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Sequences: immediate ALU RD_RD,ALU,CAPT,WB,DONE; CMI omits WB; reg-reg ALU RS_RD,RS_LAT then as immediate; CM omits WB; MI WB,DONE; MR RS_RD,RS_LAT,WB,DONE; illegal DONE with illegal=1.
REQ-025 done SHALL assert in cycle N after the accept edge: immediate 5, CMI 4, reg-reg 7, CM 6, MI 2, MR 4, illegal 1.
REQ-026 immediate_input SHALL be {6{instruction[1]}, instruction[1:0]} for immediate ops, operand register for reg-reg ops, held stable from accept to DONE.
REQ-027 rd==rs SHALL be legal and behave identically to distinct registers.
REQ-028 zf_q/cf_q SHALL change only in CAPT; MI, MR, illegal leave them unchanged.
REQ-029 illegal SHALL be valid only while done=1, else 0.
REQ-030 Outside states listed in REQ-018..REQ-022, all strobes SHALL be 0.

Reset
REQ-031 reset=1 SHALL on the same edge force IDLE; all outputs 0 except instr_ready=1; operand, result, zf_q, cf_q cleared to 0.
REQ-032 reset asserted mid-instruction SHALL abort with no WB write issued and no done pulse.
REQ-033 reset SHALL take priority over a simultaneous accept.

Verification
REQ-034 SMI 1100_0010, reg0 holds 0x29 -> immediate_input 0xFE, mode 000, WB writes reg0 with alu_result, done in cycle 5.
REQ-035 SUM 0100_0110 (rd=1, rs=2) -> RS_RD select 2, immediate_input = reg2 value, RD_RD select 1, WB to reg1, done in cycle 7.
REQ-036 CMI 1111_0001 with ALU zero_flag=1 -> no write strobe, zf_q=1, done in cycle 4.
REQ-037 MI 0010_1110 -> single write to reg3 of 0xFE, flags unchanged, done in cycle 2.
REQ-038 LD 0000_0000 -> no strobes, done=1 and illegal=1 in cycle 1.
REQ-039 Reset asserted during CAPT of SBI -> IDLE next edge, no write, no done, instr_ready=1; instr_valid held during busy cycles is not accepted.
